// File: rtl/rle_decoder.sv
// -----------------------------------------------------------------------------
// rle_decoder
//   Re-expands (value, run-count) pairs from the RLE encoder into one sample per
//   cycle for the IDCT stage. A small input FIFO absorbs pair bursts. An
//   expander FSM repeats each value count times under a valid/ready handshake.
//
//   Optional feature: define RLE_STATS_EN to add the pair_cnt / sample_cnt
//   statistics ports and counters. Without it, the ports are absent and the
//   datapath behaves identically.
//
// Parameters
//   width       sample value width (matches the encoder output)
//   DEPTH       input FIFO entries; must be a power of two, >= 2
//
// Ports
//   clk         single clock, rising edge
//   reset       synchronous, active-high reset
//   in_value    run value
//   in_count    run length 1..7; a count of 0 is illegal and is flagged
//   in_valid    pair present
//   in_ready    FIFO can accept a pair (held low while reset is high)
//   out_value   expanded sample
//   out_valid   out_value valid
//   out_ready   consumer accepts the sample
//   zero_err    sticky flag: a count==0 pair was popped; cleared only by reset
//   pair_cnt    [RLE_STATS_EN] pairs popped from the FIFO, zero pairs included
//   sample_cnt  [RLE_STATS_EN] output handshakes
// -----------------------------------------------------------------------------
module rle_decoder #(
  parameter int width = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [width-1:0] in_value,
  input  logic [2:0]       in_count,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [width-1:0] out_value,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             zero_err
`ifdef RLE_STATS_EN
  ,
  output logic [15:0]      pair_cnt,
  output logic [15:0]      sample_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [width-1:0] value;
    logic [2:0]       count;
  } pair_t;

  typedef enum logic {IDLE, EXPAND} state_t;

  // ---------------------------------------------------------------------------
  // Input FIFO
  // ---------------------------------------------------------------------------
  pair_t          mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    occ;
  logic           full, empty;
  logic           push, pop;
  pair_t          head;
  logic           head_zero;

  // Expander state
  state_t         state, state_nxt;
  logic [width-1:0] val;
  logic [2:0]     rem;
  logic           out_hs;
  logic           last_hs;
  logic           load;

  assign full      = (occ == DEPTH_CNT);
  assign empty     = (occ == '0);
  assign head      = mem[rd_ptr];
  assign head_zero = (head.count == 3'd0);

  assign in_ready  = !reset && !full;
  assign push      = in_valid && in_ready;

  assign out_hs    = out_valid && out_ready;
  // The final sample of the current run is leaving this cycle.
  assign last_hs   = out_hs && (rem == 3'd1);

  // IDLE pops whenever data is waiting; EXPAND pops only as the current run
  // ends, so the next run starts with no bubble.
  assign pop  = !empty && ((state == IDLE) || last_hs);
  assign load = pop && !head_zero;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of process order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers and the
  // occupancy count define which entries are live. Resetting it would only
  // add a wide reset fan-out for no functional gain.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{value: in_value, count: in_count};
  end

  // ---------------------------------------------------------------------------
  // Expander FSM: state register / next-state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = EXPAND;
      EXPAND:  if (last_hs && !load) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state == EXPAND);
    out_value = val;
  end

  // Run datapath and sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      val      <= '0;
      rem      <= '0;
      zero_err <= 1'b0;
    end else begin
      if (load) begin
        val <= head.value;
        rem <= head.count;
      end else if (out_hs && (rem != 3'd1)) begin
        rem <= rem - 3'd1;
      end
      if (pop && head_zero) zero_err <= 1'b1;
    end
  end

`ifdef RLE_STATS_EN
  // Free-running statistics that wrap naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      pair_cnt   <= '0;
      sample_cnt <= '0;
    end else begin
      if (pop)    pair_cnt   <= pair_cnt + 16'd1;
      if (out_hs) sample_cnt <= sample_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rle_decoder.sv
// -----------------------------------------------------------------------------
// tb_rle_decoder
//   Self-checking bench for rle_decoder (width=8, DEPTH=4). Cycle vectors cover
//   the basic expansion and stall cases. Hand-written sequences cover capacity,
//   zero-count pairs and mid-run reset. A randomized phase compares the output
//   stream against a queue model: each accepted pair appends count copies of
//   its value, and each output handshake must match the queue head.
// -----------------------------------------------------------------------------
module tb_rle_decoder;

  logic       clk;
  logic       reset;
  logic [7:0] in_value;
  logic [2:0] in_count;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_value;
  logic       out_valid;
  logic       out_ready;
  logic       zero_err;
`ifdef RLE_STATS_EN
  logic [15:0] pair_cnt;
  logic [15:0] sample_cnt;
`endif

  rle_decoder #(.width(8), .DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_value   (in_value),
    .in_count   (in_count),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_value  (out_value),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .zero_err   (zero_err)
`ifdef RLE_STATS_EN
    ,
    .pair_cnt   (pair_cnt),
    .sample_cnt (sample_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: expected output samples and expected zero_err.
  logic [7:0] exp_q[$];
  logic       exp_zero = 1'b0;

  // Stall tracking for the hold-while-stalled check.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_value = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Advance one clock. Call at a negedge with inputs already driven; returns at
  // the next negedge. Handshakes are judged from values that are stable before
  // the rising edge.
  task automatic step();
    logic in_hs, out_hs;
    if (!reset) begin
      if (prev_stall) begin
        check("stall_valid", out_valid, 1);
        check("stall_value", out_value, prev_value);
      end
      in_hs  = in_valid && in_ready;
      out_hs = out_valid && out_ready;
      if (in_hs) begin
        if (in_count == 3'd0) exp_zero = 1'b1;
        else for (int i = 0; i < int'(in_count); i++) exp_q.push_back(in_value);
      end
      if (out_hs) begin
        if (exp_q.size() == 0) fail_now("unexpected_sample");
        else check("sample", out_value, exp_q.pop_front());
      end
      prev_stall = out_valid && !out_ready;
      prev_value = out_value;
    end else begin
      prev_stall = 1'b0;
    end
    @(posedge clk);
    if (reset) begin
      exp_q.delete();
      exp_zero = 1'b0;
    end
    @(negedge clk);
  endtask

  // Offer one pair until it is accepted (bounded).
  task automatic send(input logic [7:0] v, input logic [2:0] c);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_value = v;
    in_count = c;
    while (!in_ready && n < 200) begin
      step();
      n++;
    end
    if (!in_ready) fail_now("send_timeout");
    else step();
    in_valid = 1'b0;
  endtask

  // Let the DUT empty out and confirm it ends idle.
  task automatic drain(input int bound);
    int n;
    n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() > 0 && n < bound) begin
      step();
      n++;
    end
    if (exp_q.size() > 0) fail_now("drain_timeout");
    check("idle_after_drain", out_valid, 0);
    for (int i = 0; i < 8; i++) step();
    check("still_idle", out_valid, 0);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    step();
    step();
    reset = 1'b0;
    #1;
  endtask

  typedef struct {
    logic       iv;
    logic [7:0] ival;
    logic [2:0] icnt;
    logic       ordy;
    logic       e_irdy;
    logic       e_ov;
    logic [7:0] e_val;
  } vec_t;

  vec_t vecs[17];

  initial begin
    // Back-to-back (0x12,3),(0x34,1) with out_ready=1.
    vecs[0]  = '{1'b1, 8'h12, 3'd3, 1'b1, 1'b1, 1'b0, 8'h00};
    vecs[1]  = '{1'b1, 8'h34, 3'd1, 1'b1, 1'b1, 1'b0, 8'h00};
    vecs[2]  = '{1'b0, 8'h00, 3'd0, 1'b1, 1'b1, 1'b1, 8'h12};
    vecs[3]  = '{1'b0, 8'h00, 3'd0, 1'b1, 1'b1, 1'b1, 8'h12};
    vecs[4]  = '{1'b0, 8'h00, 3'd0, 1'b1, 1'b1, 1'b1, 8'h12};
    vecs[5]  = '{1'b0, 8'h00, 3'd0, 1'b1, 1'b1, 1'b1, 8'h34};
    vecs[6]  = '{1'b0, 8'h00, 3'd0, 1'b1, 1'b1, 1'b0, 8'h00};
    // (0xA5,4) with out_ready 1,0,0,1,1,0,1 while valid.
    vecs[7]  = '{1'b1, 8'hA5, 3'd4, 1'b1, 1'b1, 1'b0, 8'h00};
    vecs[8]  = '{1'b0, 8'h00, 3'd0, 1'b1, 1'b1, 1'b0, 8'h00};
    vecs[9]  = '{1'b0, 8'h00, 3'd0, 1'b1, 1'b1, 1'b1, 8'hA5};
    vecs[10] = '{1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 1'b1, 8'hA5};
    vecs[11] = '{1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 1'b1, 8'hA5};
    vecs[12] = '{1'b0, 8'h00, 3'd0, 1'b1, 1'b1, 1'b1, 8'hA5};
    vecs[13] = '{1'b0, 8'h00, 3'd0, 1'b1, 1'b1, 1'b1, 8'hA5};
    vecs[14] = '{1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 1'b1, 8'hA5};
    vecs[15] = '{1'b0, 8'h00, 3'd0, 1'b1, 1'b1, 1'b1, 8'hA5};
    vecs[16] = '{1'b0, 8'h00, 3'd0, 1'b1, 1'b1, 1'b0, 8'h00};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_value  = 8'h00;
    in_count  = 3'd0;
    out_ready = 1'b0;

    // Reset state.
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_value", out_value, 0);
    check("rst_zero_err", zero_err, 0);
    check("rst_in_ready", in_ready, 0);
    step();
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // Cycle vectors.
    for (int i = 0; i < 17; i++) begin
      in_valid  = vecs[i].iv;
      in_value  = vecs[i].ival;
      in_count  = vecs[i].icnt;
      out_ready = vecs[i].ordy;
      check($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].e_irdy);
      check($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].e_ov);
      if (vecs[i].e_ov) check($sformatf("vec%0d_out_value", i), out_value, vecs[i].e_val);
      step();
    end
    check("vec_queue_empty", exp_q.size(), 0);

    // Capacity: with out_ready=0, 5 of 7 offered pairs are accepted.
    begin
      int accepted;
      accepted  = 0;
      out_ready = 1'b0;
      for (int k = 0; k < 7; k++) begin
        in_valid = 1'b1;
        in_value = 8'h40 + 8'(accepted);
        in_count = 3'(accepted % 3 + 1);
        if (in_ready) accepted++;
        step();
      end
      in_valid = 1'b0;
      check("cap_accepted", accepted, 5);
      check("cap_in_ready_low", in_ready, 0);
      step();
      check("cap_in_ready_held", in_ready, 0);
      drain(200);
    end

    // Zero-count pair is discarded and flagged.
    out_ready = 1'b1;
    send(8'h10, 3'd2);
    send(8'h55, 3'd0);
    send(8'h20, 3'd1);
    drain(100);
    check("zero_err_set", zero_err, 1);
    for (int i = 0; i < 5; i++) step();
    check("zero_err_held", zero_err, 1);

    // Reset mid-run after two samples.
    begin
      int n;
      n = 0;
      out_ready = 1'b1;
      send(8'h7F, 3'd6);
      while (exp_q.size() > 4 && n < 50) begin
        step();
        n++;
      end
      check("mid_remaining", exp_q.size(), 4);
      check("mid_out_valid", out_valid, 1);
      reset = 1'b1;
      step();
      check("mr_out_valid", out_valid, 0);
      check("mr_in_ready", in_ready, 0);
      check("mr_zero_err", zero_err, 0);
      reset = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) step();
      check("mr_empty_no_output", out_valid, 0);
      check("mr_in_ready_after", in_ready, 1);
    end

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      in_value  = 8'($urandom);
      in_count  = 3'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    drain(2000);
    check("rand_zero_err", zero_err, exp_zero);

`ifdef RLE_STATS_EN
    do_reset();
    out_ready = 1'b1;
    send(8'h01, 3'd3);
    send(8'h02, 3'd7);
    drain(100);
    check("stats_pair_cnt", pair_cnt, 2);
    check("stats_sample_cnt", sample_cnt, 10);
`else
    do_reset();
    check("final_reset_valid", out_valid, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
